// File: rtl/dpi_pattern_gen.sv
// Test-pattern pixel source between the DPI timing generator and the pin mapping.
// Optional `CROSSHAIR_EN overlays a white crosshair at the screen centre in stage 2.
module dpi_pattern_gen #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int FPS      = 60,
    parameter int BAR_STEP = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_hsync,
    input  logic        in_vsync,
    input  logic        in_blank,
    input  logic [9:0]  in_x,
    input  logic [9:0]  in_y,
    input  logic [2:0]  pat_sel,
    input  logic        pat_sel_valid,
    output logic        out_hsync,
    output logic        out_vsync,
    output logic        out_de,
    output logic [17:0] out_color,
    output logic [2:0]  cur_pattern,
    output logic        sec_tick
);

    typedef enum logic {MODE_MANUAL, MODE_AUTO} mode_t;

    localparam int          FC_W   = $clog2(FPS + 1);
    localparam int          BAR_W  = H_ACTIVE / 8;
    localparam logic [9:0]  X_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0]  Y_LAST = 10'(V_ACTIVE - 1);

    localparam logic [17:0] C_WHITE   = 18'h3ffff;
    localparam logic [17:0] C_YELLOW  = 18'h3ffc0;
    localparam logic [17:0] C_CYAN    = 18'h00fff;
    localparam logic [17:0] C_GREEN   = 18'h00fc0;
    localparam logic [17:0] C_MAGENTA = 18'h3f03f;
    localparam logic [17:0] C_RED     = 18'h3f000;
    localparam logic [17:0] C_BLUE    = 18'h0003f;
    localparam logic [17:0] C_BLACK   = 18'h00000;

    // Stage 1 registers
    logic       s1_hsync, s1_vsync, s1_de;
    logic [9:0] s1_x, s1_y;

    // Control state
    mode_t            mode;
    logic [2:0]       cur_pat;
    logic [2:0]       pend;
    logic             pend_v;
    logic [FC_W-1:0]  frame_cnt;
    logic [9:0]       bar_pos;

    logic        frame_edge;
    logic        fc_wrap;
    logic [10:0] bar_sum;
    logic [10:0] bar_end;
    logic [9:0]  bar_idx;
    logic [17:0] pat_color;
    logic [17:0] color_ov;

    assign frame_edge  = in_vsync & ~s1_vsync;
    assign fc_wrap     = (frame_cnt == FC_W'(FPS - 1));
    assign bar_sum     = {1'b0, bar_pos} + 11'(BAR_STEP);
    assign bar_end     = {1'b0, bar_pos} + 11'd16;
    assign bar_idx     = s1_x / 10'(BAR_W);
    assign cur_pattern = cur_pat;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            s1_hsync <= 1'b0;
            s1_vsync <= 1'b0;
            s1_de    <= 1'b0;
            s1_x     <= '0;
            s1_y     <= '0;
        end else begin
            s1_hsync <= in_hsync;
            s1_vsync <= in_vsync;
            s1_de    <= ~in_blank;
            s1_x     <= in_x;
            s1_y     <= in_y;
        end
    end

    // pat_sel_valid is a fire-and-forget strobe with no ready: the last strobe
    // before a frame edge wins, and a strobe on the edge cycle waits one frame.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            mode      <= MODE_MANUAL;
            cur_pat   <= '0;
            pend      <= '0;
            pend_v    <= 1'b0;
            frame_cnt <= '0;
            bar_pos   <= '0;
            sec_tick  <= 1'b0;
        end else begin
            sec_tick <= 1'b0;
            if (frame_edge) begin
                if (fc_wrap) begin
                    frame_cnt <= '0;
                    sec_tick  <= 1'b1;
                end else begin
                    frame_cnt <= frame_cnt + FC_W'(1);
                end
                if (bar_sum >= 11'(H_ACTIVE))
                    bar_pos <= 10'(bar_sum - 11'(H_ACTIVE));
                else
                    bar_pos <= bar_sum[9:0];
                // A manual request applied on this edge overrides the auto advance.
                if (pend_v) begin
                    pend_v <= 1'b0;
                    if (pend == 3'd7) begin
                        mode <= MODE_AUTO;
                    end else begin
                        mode    <= MODE_MANUAL;
                        cur_pat <= pend;
                    end
                end else if (mode == MODE_AUTO && fc_wrap) begin
                    cur_pat <= (cur_pat >= 3'd5) ? 3'd0 : cur_pat + 3'd1;
                end
            end
            if (pat_sel_valid) begin
                pend   <= pat_sel;
                pend_v <= 1'b1;
            end
        end
    end

    always_comb begin
        pat_color = C_BLACK;
        case (cur_pat)
            3'd0: begin
                if (s1_x < 10'd213)      pat_color = C_RED;
                else if (s1_x < 10'd426) pat_color = C_WHITE;
                else                     pat_color = C_BLUE;
            end
            3'd1: pat_color = (s1_x[4] ^ s1_y[4]) ? C_WHITE : C_RED;
            3'd2: begin
                case (bar_idx)
                    10'd0:   pat_color = C_WHITE;
                    10'd1:   pat_color = C_YELLOW;
                    10'd2:   pat_color = C_CYAN;
                    10'd3:   pat_color = C_GREEN;
                    10'd4:   pat_color = C_MAGENTA;
                    10'd5:   pat_color = C_RED;
                    10'd6:   pat_color = C_BLUE;
                    default: pat_color = C_BLACK;
                endcase
            end
            3'd3: pat_color = {s1_x[9:4], s1_x[9:4], s1_x[9:4]};
            3'd4: begin
                if ({1'b0, s1_x} >= {1'b0, bar_pos} && {1'b0, s1_x} < bar_end)
                    pat_color = C_WHITE;
            end
            3'd5: begin
                if (s1_x == 10'd0 || s1_x == X_LAST || s1_y == 10'd0 || s1_y == Y_LAST)
                    pat_color = C_WHITE;
            end
            default: pat_color = C_BLACK;
        endcase
    end

`ifdef CROSSHAIR_EN
    always_comb begin
        color_ov = pat_color;
        if (s1_x == 10'(H_ACTIVE / 2) || s1_y == 10'(V_ACTIVE / 2))
            color_ov = C_WHITE;
    end
`else
    assign color_ov = pat_color;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_hsync <= 1'b0;
            out_vsync <= 1'b0;
            out_de    <= 1'b0;
            out_color <= '0;
        end else begin
            out_hsync <= s1_hsync;
            out_vsync <= s1_vsync;
            out_de    <= s1_de;
            out_color <= s1_de ? color_ov : C_BLACK;
        end
    end

endmodule
